stream_minmax: RTL and testbench
================================

# stream_minmax

Frame-based signed min/max tracker that sits directly downstream of `comparator_lt` and `comparator_eq`. It accepts a valid/ready stream of N-bit values grouped into frames by `in_last`. Each accepted sample is compared against the running extremes using one instance of each comparator. At frame end it emits min, max, sample count and the number of samples equal to the final max through a valid/ready output register.

## Interface
- `N`, 32, data width; signed two's complement.
- `CW`, 16, width of the count and hit counters; both saturate.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low. One clock; reset is asynchronous and active-low.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  block can accept a sample; equals `!out_valid`.
- `in_data`  in  N  sample value.
- `in_last`  in  1  qualifies the final sample of a frame; sampled only on an accepted beat.
- `out_valid`  out  1  frame result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_min`  out  N  smallest sample of the frame.
- `out_max`  out  N  largest sample of the frame.
- `out_count`  out  CW  number of samples in the frame, saturating at 2^CW-1.
- `out_hits`  out  CW  number of samples equal to `out_max`, saturating.

## Operation
- A beat is accepted when `in_valid && in_ready`. A result is taken when `out_valid && out_ready`.
- FSM states:
  - EMPTY: no sample in the current frame. Reset state.
  - ACCUM: at least one sample held.
  - HOLD: result presented, `out_valid` = 1.
- EMPTY + beat: `min=max=in_data`, `count=1`, `hits=1`. Go to HOLD if `in_last`, else ACCUM.
- ACCUM + beat: the comparators are fed (`in_data`, `min`) for lt and (`max`, `in_data`) for lt, plus (`in_data`, `max`) for eq.
  - If `in_data < min`: `min <= in_data`.
  - If `max < in_data`: `max <= in_data`, `hits <= 1`.
  - Else if `in_data == max`: `hits <= hits+1`, saturating.
  - `count <= count+1`, saturating at 2^CW-1. Saturated counts stay at the maximum and never wrap.
  - If `in_last`: go to HOLD.
- Entering HOLD copies the updated values into the `out_*` registers. These include the contribution of the last beat.
- HOLD: all `out_*` stay stable until the result handshake, then the FSM returns to EMPTY.
- `in_valid` without `in_ready` has no effect. `in_data` and `in_last` are ignored on non-accepted cycles.
- A frame of exactly one beat with `in_last` is legal: min = max = that sample, count = 1, hits = 1.
- Reset mid-frame or in HOLD discards all partial state. No result is emitted for the interrupted frame.

## Timing
- Reset values:
  - `out_valid`=0, `in_ready`=1.
  - `out_min`, `out_max`, `out_count`, `out_hits` = 0.
  - Internal min/max/count/hits = 0; FSM in EMPTY.
- Throughput: one sample per cycle inside a frame.
- Latency: `out_valid` rises on the clock edge that accepts the `in_last` beat. Results are visible in the following cycle.
- `in_ready` falls in the same cycle `out_valid` rises. It returns high the cycle after the result handshake, so there is no overlap: a new frame's first beat cannot be accepted in the handshake cycle.
- `out_valid` with `out_ready` low: the block holds indefinitely with no timeout.
- Comparators are purely combinational within the same cycle; there is no extra pipeline stage.

## Configuration
- `STREAM_MINMAX_UNSIGNED_EN`:
  - Defined: all comparisons are unsigned. The implementation XORs bit N-1 of both operands of each `comparator_lt` instance; `comparator_eq` is unchanged.
  - Undefined (default): signed comparison.
  - Reset values and handshake are identical in both builds.

## Test plan
- Reset and single-beat frame: release `rst_n`, send 5 with `in_last` -> `out_valid` next cycle, min=max=5, count=1, hits=1, `in_ready`=0 while held.
- Signed extremes: frame {0, -1, 0x7FFFFFFF, 0x80000000, 1 last} -> min=0x80000000, max=0x7FFFFFFF, count=5, hits=1. With `STREAM_MINMAX_UNSIGNED_EN`: min=0, max=0xFFFFFFFF.
- Ties: frame {3, 7, 7, 2, 7 last} -> min=2, max=7, count=5, hits=3. Then frame {7, 9 last} -> hits reset to 1, max=9.
- Backpressure: hold `out_ready`=0 for 4 cycles -> outputs stable, `in_ready`=0, `in_valid` pulses ignored. After the handshake, `in_ready`=1 on the next cycle only.
- Mid-frame reset: send {10, -4} without last, assert `rst_n`=0 asynchronously -> all outputs 0 immediately. Then frame {6 last} -> min=max=6, count=1.
- Saturation with CW=2: frame of 5 equal samples 1 -> count=3, hits=3.

Source files
------------

// File: rtl/stream_minmax.sv
// Frame-based min/max/count/hits tracker over a valid/ready stream, with one result per frame.
// Build option: define STREAM_MINMAX_UNSIGNED_EN to compare samples as unsigned instead of signed.

module comparator_lt #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);
    assign lt = $signed(a) < $signed(b);
endmodule

module comparator_eq #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         eq
);
    assign eq = (a == b);
endmodule

module stream_minmax #(
    parameter int N  = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_min,
    output logic [N-1:0]  out_max,
    output logic [CW-1:0] out_count,
    output logic [CW-1:0] out_hits
);
    typedef enum logic [1:0] {EMPTY, ACCUM, HOLD} state_t;

    localparam logic [CW-1:0] C_SAT = '1;
    localparam logic [CW-1:0] C_ONE = CW'(1);

`ifdef STREAM_MINMAX_UNSIGNED_EN
    // Flipping the sign bit makes the signed comparator order operands as unsigned.
    localparam logic [N-1:0] C_FLIP = {1'b1, {(N-1){1'b0}}};
`else
    localparam logic [N-1:0] C_FLIP = '0;
`endif

    state_t        r_state;
    logic [N-1:0]  r_min;
    logic [N-1:0]  r_max;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_hits;
    logic          r_out_valid;
    logic [N-1:0]  r_out_min;
    logic [N-1:0]  r_out_max;
    logic [CW-1:0] r_out_count;
    logic [CW-1:0] r_out_hits;

    logic          w_lt_min;
    logic          w_gt_max;
    logic          w_eq_max;
    logic          w_accept;
    logic          w_first;
    logic [N-1:0]  w_nxt_min;
    logic [N-1:0]  w_nxt_max;
    logic [CW-1:0] w_nxt_count;
    logic [CW-1:0] w_nxt_hits;

    comparator_lt #(.N(N)) u_lt_min (
        .a  (in_data ^ C_FLIP),
        .b  (r_min ^ C_FLIP),
        .lt (w_lt_min)
    );

    comparator_lt #(.N(N)) u_lt_max (
        .a  (r_max ^ C_FLIP),
        .b  (in_data ^ C_FLIP),
        .lt (w_gt_max)
    );

    comparator_eq #(.N(N)) u_eq_max (
        .a  (in_data),
        .b  (r_max),
        .eq (w_eq_max)
    );

    assign w_accept = in_valid && !r_out_valid;
    assign w_first  = (r_state == EMPTY);

    // Running values after absorbing the current beat; the first beat of a frame seeds everything.
    always_comb begin
        w_nxt_min   = r_min;
        w_nxt_max   = r_max;
        w_nxt_count = r_count;
        w_nxt_hits  = r_hits;
        if (w_first) begin
            w_nxt_min   = in_data;
            w_nxt_max   = in_data;
            w_nxt_count = C_ONE;
            w_nxt_hits  = C_ONE;
        end else begin
            if (w_lt_min)
                w_nxt_min = in_data;
            if (w_gt_max) begin
                w_nxt_max  = in_data;
                w_nxt_hits = C_ONE;
            end else if (w_eq_max && r_hits != C_SAT) begin
                w_nxt_hits = r_hits + C_ONE;
            end
            if (r_count != C_SAT)
                w_nxt_count = r_count + C_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_min       <= '0;
            r_max       <= '0;
            r_count     <= '0;
            r_hits      <= '0;
            r_out_valid <= 1'b0;
            r_out_min   <= '0;
            r_out_max   <= '0;
            r_out_count <= '0;
            r_out_hits  <= '0;
        end else begin
            case (r_state)
                EMPTY, ACCUM: begin
                    if (w_accept) begin
                        r_min   <= w_nxt_min;
                        r_max   <= w_nxt_max;
                        r_count <= w_nxt_count;
                        r_hits  <= w_nxt_hits;
                        if (in_last) begin
                            r_out_min   <= w_nxt_min;
                            r_out_max   <= w_nxt_max;
                            r_out_count <= w_nxt_count;
                            r_out_hits  <= w_nxt_hits;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= EMPTY;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

    assign in_ready  = !r_out_valid;
    assign out_valid = r_out_valid;
    assign out_min   = r_out_min;
    assign out_max   = r_out_max;
    assign out_count = r_out_count;
    assign out_hits  = r_out_hits;

endmodule

// File: tb/tb_stream_minmax.sv
// Randomized and directed bench for stream_minmax, with a frame-level reference model.
module tb_stream_minmax;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready, out_valid;
    logic [31:0] out_min, out_max;
    logic [15:0] out_count, out_hits;

    logic        s_in_valid = 1'b0, s_in_last = 1'b0, s_out_ready = 1'b0;
    logic [31:0] s_in_data = '0;
    logic        s_in_ready, s_out_valid;
    logic [31:0] s_out_min, s_out_max;
    logic [1:0]  s_out_count, s_out_hits;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] frame_q[$];

    always #5 clk = ~clk;

    stream_minmax #(.N(32), .CW(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_min(out_min), .out_max(out_max), .out_count(out_count), .out_hits(out_hits)
    );

    stream_minmax #(.N(32), .CW(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_data(s_in_data), .in_last(s_in_last), .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_min(s_out_min), .out_max(s_out_max), .out_count(s_out_count), .out_hits(s_out_hits)
    );

    function automatic bit lt_ref(logic [31:0] a, logic [31:0] b);
`ifdef STREAM_MINMAX_UNSIGNED_EN
        return a < b;
`else
        return $signed(a) < $signed(b);
`endif
    endfunction

    // Whole-frame reference: extremes over the frame, then count of samples equal to the max.
    task automatic model(output logic [31:0] mn, output logic [31:0] mx,
                         output logic [15:0] c, output logic [15:0] h, input int cw);
        int hits = 0;
        int sat = (1 << cw) - 1;
        mn = frame_q[0];
        mx = frame_q[0];
        foreach (frame_q[i]) begin
            if (lt_ref(frame_q[i], mn)) mn = frame_q[i];
            if (lt_ref(mx, frame_q[i])) mx = frame_q[i];
        end
        foreach (frame_q[i]) if (frame_q[i] == mx) hits++;
        c = 16'((frame_q.size() > sat) ? sat : frame_q.size());
        h = 16'((hits > sat) ? sat : hits);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic l);
        in_valid = 1'b1; in_data = d; in_last = l;
        frame_q.push_back(d);
        tick();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        frame_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        n_tests++;
        if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b0, 1'b1, 96'd0}) begin
            n_fail++;
            $display("FAIL reset: valid=%b ready=%b min=%h max=%h cnt=%0d hits=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_min, out_max, out_count, out_hits);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        send_beat(32'd5, 1'b1);
        repeat (2) begin
            n_tests++;
            if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b1, 1'b0, 32'd5, 32'd5, 16'd1, 16'd1}) begin
                n_fail++;
                $display("FAIL single: valid=%b ready=%b min=%h max=%h cnt=%0d hits=%0d, want 1 0 5 5 1 1",
                         out_valid, in_ready, out_min, out_max, out_count, out_hits);
            end
            tick();
        end
        handshake();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL single_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_signed_extremes();
        logic [31:0] emin, emax;
`ifdef STREAM_MINMAX_UNSIGNED_EN
        emin = 32'h0000_0000; emax = 32'hFFFF_FFFF;
`else
        emin = 32'h8000_0000; emax = 32'h7FFF_FFFF;
`endif
        send_beat(32'd0, 1'b0);
        send_beat(32'hFFFF_FFFF, 1'b0);
        send_beat(32'h7FFF_FFFF, 1'b0);
        send_beat(32'h8000_0000, 1'b0);
        send_beat(32'd1, 1'b1);
        n_tests++;
        if ({out_valid, out_min, out_max, out_count, out_hits} !== {1'b1, emin, emax, 16'd5, 16'd1}) begin
            n_fail++;
            $display("FAIL extremes: valid=%b min=%h max=%h cnt=%0d hits=%0d, want 1 %h %h 5 1",
                     out_valid, out_min, out_max, out_count, out_hits, emin, emax);
        end
        handshake();
    endtask

    task automatic test_ties();
        send_beat(32'd3, 1'b0);
        send_beat(32'd7, 1'b0);
        send_beat(32'd7, 1'b0);
        send_beat(32'd2, 1'b0);
        send_beat(32'd7, 1'b1);
        n_tests++;
        if ({out_valid, out_min, out_max, out_count, out_hits} !== {1'b1, 32'd2, 32'd7, 16'd5, 16'd3}) begin
            n_fail++;
            $display("FAIL ties: min=%0d max=%0d cnt=%0d hits=%0d, want 2 7 5 3",
                     out_min, out_max, out_count, out_hits);
        end
        handshake();
        send_beat(32'd7, 1'b0);
        send_beat(32'd9, 1'b1);
        n_tests++;
        if ({out_valid, out_min, out_max, out_count, out_hits} !== {1'b1, 32'd7, 32'd9, 16'd2, 16'd1}) begin
            n_fail++;
            $display("FAIL ties_newmax: min=%0d max=%0d cnt=%0d hits=%0d, want 7 9 2 1",
                     out_min, out_max, out_count, out_hits);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        send_beat(32'd4, 1'b0);
        send_beat(32'hFFFF_FFF0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_valid = i[0]; in_data = $urandom; in_last = 1'b1;
            tick();
            n_tests++;
`ifdef STREAM_MINMAX_UNSIGNED_EN
            if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b1, 1'b0, 32'd4, 32'hFFFF_FFF0, 16'd2, 16'd1}) begin
`else
            if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b1, 1'b0, 32'hFFFF_FFF0, 32'd4, 16'd2, 16'd1}) begin
`endif
                n_fail++;
                $display("FAIL backpressure_hold[%0d]: valid=%b ready=%b min=%h max=%h cnt=%0d hits=%0d",
                         i, out_valid, in_ready, out_min, out_max, out_count, out_hits);
            end
        end
        // A beat offered during the handshake cycle must be ignored.
        in_valid = 1'b1; in_data = 32'd100; in_last = 1'b1;
        handshake();
        n_tests++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL backpressure_release: valid=%b ready=%b, want 0 1", out_valid, in_ready);
        end
        in_valid = 1'b0; in_last = 1'b0;
        send_beat(32'd2, 1'b1);
        n_tests++;
        if ({out_valid, out_min, out_max, out_count, out_hits} !== {1'b1, 32'd2, 32'd2, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL backpressure_next: min=%0d max=%0d cnt=%0d hits=%0d, want 2 2 1 1",
                     out_min, out_max, out_count, out_hits);
        end
        handshake();
    endtask

    task automatic test_midframe_reset();
        send_beat(32'd10, 1'b0);
        send_beat(32'hFFFF_FFFC, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b0, 1'b1, 96'd0}) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b ready=%b min=%h max=%h cnt=%0d hits=%0d, want 0 1 0 0 0 0",
                     out_valid, in_ready, out_min, out_max, out_count, out_hits);
        end
        tick();
        rst_n = 1'b1;
        frame_q.delete();
        tick();
        send_beat(32'd6, 1'b1);
        n_tests++;
        if ({out_valid, out_min, out_max, out_count, out_hits} !== {1'b1, 32'd6, 32'd6, 16'd1, 16'd1}) begin
            n_fail++;
            $display("FAIL after_reset: min=%0d max=%0d cnt=%0d hits=%0d, want 6 6 1 1",
                     out_min, out_max, out_count, out_hits);
        end
        handshake();
    endtask

    task automatic test_random();
        logic [31:0] emin, emax;
        logic [15:0] ec, eh;
        for (int f = 0; f < 25; f++) begin
            int len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                logic [31:0] d;
                if ($urandom_range(0, 1) == 1) d = 32'($urandom_range(0, 6)) - 32'd3;
                else d = $urandom;
                repeat ($urandom_range(0, 2)) tick();
                send_beat(d, (k == len - 1) ? 1'b1 : 1'b0);
            end
            model(emin, emax, ec, eh, 16);
            repeat ($urandom_range(0, 3)) tick();
            n_tests++;
            if ({out_valid, in_ready, out_min, out_max, out_count, out_hits} !== {1'b1, 1'b0, emin, emax, ec, eh}) begin
                n_fail++;
                $display("FAIL random_frame[%0d]: valid=%b ready=%b min=%h max=%h cnt=%0d hits=%0d, want min=%h max=%h cnt=%0d hits=%0d",
                         f, out_valid, in_ready, out_min, out_max, out_count, out_hits, emin, emax, ec, eh);
            end
            handshake();
        end
    endtask

    task automatic test_saturation();
        logic [31:0] emin, emax;
        logic [15:0] ec, eh;
        for (int f = 0; f < 3; f++) begin
            frame_q.delete();
            for (int k = 0; k < 5; k++)
                frame_q.push_back((f == 0) ? 32'd1 : (f == 1) ? ((k == 0) ? 32'd3 : 32'd1) : ((k < 1) ? 32'd1 : 32'd2));
            for (int k = 0; k < 5; k++) begin
                s_in_valid = 1'b1; s_in_data = frame_q[k]; s_in_last = (k == 4);
                tick();
            end
            s_in_valid = 1'b0; s_in_last = 1'b0;
            model(emin, emax, ec, eh, 2);
            n_tests++;
            if ({s_out_valid, s_out_min, s_out_max, s_out_count, s_out_hits} !== {1'b1, emin, emax, ec[1:0], eh[1:0]}) begin
                n_fail++;
                $display("FAIL saturation[%0d]: min=%0d max=%0d cnt=%0d hits=%0d, want %0d %0d %0d %0d",
                         f, s_out_min, s_out_max, s_out_count, s_out_hits, emin, emax, ec, eh);
            end
            s_out_ready = 1'b1;
            tick();
            s_out_ready = 1'b0;
        end
        frame_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed_extremes();
        test_ties();
        test_backpressure();
        test_midframe_reset();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
